// File: rtl/packet_switch_pkg.sv
// Shared port-index encoding for the packet switch timestamp path.
// The TS demux decoder reads the same field positions back out of the returned fingerprint.
package packet_switch_pkg;

  localparam int PORTS_WIDTH = 4;

  typedef enum logic [PORTS_WIDTH-1:0] {
    PT_DMA0 = 4'd0,
    PT_DMA1 = 4'd1,
    PT_DMA2 = 4'd2,
    PT_DMA3 = 4'd3,
    PT_DMA4 = 4'd4,
    PT_DMA5 = 4'd5,
    PT_DMA6 = 4'd6,
    PT_DMA7 = 4'd7,
    PT_USER = 4'd8
  } port_idx_e;

endpackage

// File: rtl/packet_switch_rr_arb.sv
// Round-robin arbiter: the search starts one past the last winner and wraps.
// last_grant moves only when something is actually granted.
module packet_switch_rr_arb #(
  parameter int N     = 9,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] scan_idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = '0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        scan_idx = IDX_W'((int'(last_grant) + k) % N);
        if (!found && req[scan_idx]) begin
          found           = 1'b1;
          grant[scan_idx] = 1'b1;
          grant_idx       = scan_idx;
        end
      end
    end
  end

  // Parking on N-1 after reset gives port 0 first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(N - 1);
    end else if (found) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/packet_switch_dma_ts_fp_mux.sv
// TX timestamp-request tagger: arbitrates requesters, stamps the port index into
// the fingerprint and bounds in-flight requests per port.
module packet_switch_dma_ts_fp_mux
  import packet_switch_pkg::*;
#(
  parameter int FINGERPRINT_FLD_WIDTH = 32,
  parameter int SYS_FINGERPRINT_WIDTH = 20,
  parameter int NUM_INTF              = 9,
  parameter int MAX_OUTSTANDING       = 16
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NUM_INTF-1:0]                              egrpt2mux_tvalid,
  input  logic [NUM_INTF-1:0][FINGERPRINT_FLD_WIDTH-1:0]   egrpt2mux_fp,
  output logic [NUM_INTF-1:0]                              mux2egrpt_tready,
  output logic                                             mux2hssi_tvalid,
  output logic [FINGERPRINT_FLD_WIDTH-1:0]                 mux2hssi_fp,
  input  logic                                             hssi2mux_tready,
  input  logic [NUM_INTF-1:0]                              ts_ret_valid,
  output logic [NUM_INTF-1:0]                              underflow_err,
  output logic [NUM_INTF-1:0]                              outstanding_full
);

  localparam int IDX_W = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_INTF-1:0]              eligible;
  logic [NUM_INTF-1:0]              grant;
  logic [IDX_W-1:0]                 grant_idx;
  logic                             slot_free;
  logic [FINGERPRINT_FLD_WIDTH-1:0] fp_next;
  logic [CNT_W-1:0]                 cnt [NUM_INTF];
  logic                             unused_fp_bits;

  always_comb begin
    for (int i = 0; i < NUM_INTF; i++) begin
      eligible[i] = egrpt2mux_tvalid[i] && (cnt[i] < CNT_MAX);
    end
  end

  assign slot_free = !mux2hssi_tvalid || hssi2mux_tready;

  // Gating with rst_n keeps every tready low during reset cycles.
  packet_switch_rr_arb #(
    .N     (NUM_INTF),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (eligible),
    .en        (slot_free && rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign mux2egrpt_tready = grant;

  always_comb begin
    fp_next = '0;
    fp_next[SYS_FINGERPRINT_WIDTH-1:0] = egrpt2mux_fp[grant_idx][SYS_FINGERPRINT_WIDTH-1:0];
    fp_next[SYS_FINGERPRINT_WIDTH +: PORTS_WIDTH] = PORTS_WIDTH'(grant_idx);
  end

  // Requesters may drive anything above the system fingerprint; it is overwritten.
  always_comb begin
    unused_fp_bits = 1'b0;
    for (int i = 0; i < NUM_INTF; i++) begin
      unused_fp_bits = unused_fp_bits ^
                       (^egrpt2mux_fp[i][FINGERPRINT_FLD_WIDTH-1:SYS_FINGERPRINT_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux2hssi_tvalid <= 1'b0;
      mux2hssi_fp     <= '0;
    end else if (|grant) begin
      mux2hssi_tvalid <= 1'b1;
      mux2hssi_fp     <= fp_next;
    end else if (hssi2mux_tready) begin
      mux2hssi_tvalid <= 1'b0;
    end
  end

  // A port at the limit is never eligible, so the increment cannot overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INTF; i++) begin
        cnt[i] <= '0;
      end
      underflow_err    <= '0;
      outstanding_full <= '0;
    end else begin
      for (int i = 0; i < NUM_INTF; i++) begin
        outstanding_full[i] <= (cnt[i] == CNT_MAX);
        case ({grant[i], ts_ret_valid[i]})
          2'b10: cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01: begin
            if (cnt[i] == '0) begin
              underflow_err[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end
          end
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_switch_dma_ts_fp_mux.sv
// Directed vector bench for the timestamp-request tagger (MAX_OUTSTANDING = 4).
// Port i drives fingerprint {12'hC3C, base ^ i}; expected values are hand-computed.
module tb_packet_switch_dma_ts_fp_mux;

  localparam int FW = 32;
  localparam int NI = 9;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NI-1:0]          egrpt2mux_tvalid = '0;
  logic [NI-1:0][FW-1:0]  egrpt2mux_fp = '0;
  logic [NI-1:0]          mux2egrpt_tready;
  logic                   mux2hssi_tvalid;
  logic [FW-1:0]          mux2hssi_fp;
  logic                   hssi2mux_tready = 1'b0;
  logic [NI-1:0]          ts_ret_valid = '0;
  logic [NI-1:0]          underflow_err;
  logic [NI-1:0]          outstanding_full;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  packet_switch_dma_ts_fp_mux #(
    .FINGERPRINT_FLD_WIDTH (32),
    .SYS_FINGERPRINT_WIDTH (20),
    .NUM_INTF              (9),
    .MAX_OUTSTANDING       (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .egrpt2mux_tvalid (egrpt2mux_tvalid),
    .egrpt2mux_fp     (egrpt2mux_fp),
    .mux2egrpt_tready (mux2egrpt_tready),
    .mux2hssi_tvalid  (mux2hssi_tvalid),
    .mux2hssi_fp      (mux2hssi_fp),
    .hssi2mux_tready  (hssi2mux_tready),
    .ts_ret_valid     (ts_ret_valid),
    .underflow_err    (underflow_err),
    .outstanding_full (outstanding_full)
  );

  typedef struct {
    logic        rst_n;
    logic [8:0]  tvalid;
    logic [19:0] fp;
    logic        hready;
    logic [8:0]  ret;
    logic [8:0]  exp_tready;
    logic        exp_valid;
    logic        chk_fp;
    logic [31:0] exp_fp;
    logic [8:0]  exp_full;
    logic [8:0]  exp_uf;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [8:0] tv, input logic [19:0] fp,
                              input logic hr, input logic [8:0] ret, input logic [8:0] etr,
                              input logic ev, input logic cf, input logic [31:0] efp,
                              input logic [8:0] efull, input logic [8:0] euf);
    vec_t v;
    v.rst_n = r;   v.tvalid = tv;      v.fp = fp;        v.hready = hr;  v.ret = ret;
    v.exp_tready = etr; v.exp_valid = ev; v.chk_fp = cf; v.exp_fp = efp;
    v.exp_full = efull; v.exp_uf = euf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", nm, n_vec, act, exp);
    end
  endtask

  // Drive at posedge+1, check tready at negedge, registered outputs at next posedge+1.
  task automatic apply(input vec_t v);
    rst_n            = v.rst_n;
    egrpt2mux_tvalid = v.tvalid;
    for (int i = 0; i < NI; i++) begin
      egrpt2mux_fp[i] = {12'hC3C, v.fp ^ 20'(i)};
    end
    hssi2mux_tready = v.hready;
    ts_ret_valid    = v.ret;
    @(negedge clk);
    chk("tready", 32'(mux2egrpt_tready), 32'(v.exp_tready));
    @(posedge clk);
    #1;
    chk("tvalid", 32'(mux2hssi_tvalid), 32'(v.exp_valid));
    if (v.chk_fp) chk("fp", mux2hssi_fp, v.exp_fp);
    chk("full", 32'(outstanding_full), 32'(v.exp_full));
    chk("underflow", 32'(underflow_err), 32'(v.exp_uf));
    n_vec++;
  endtask

  vec_t tbl[$];

  initial begin
    // reset, single request, round-robin over all ports
    tbl.push_back(mk(0, 9'h1FF, 20'h00000, 1, 9'h000, 9'h000, 0, 1, 32'h0, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h004, 20'h0ABCDC, 1, 9'h000, 9'h004, 1, 1, 32'h002ABCDE, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h000, 20'h0ABCDC, 1, 9'h000, 9'h000, 0, 1, 32'h002ABCDE, 9'h0, 9'h0));
    tbl.push_back(mk(0, 9'h000, 20'h00000, 1, 9'h000, 9'h000, 0, 1, 32'h0, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h001, 1, 1, 32'h00012340, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h002, 1, 1, 32'h00112341, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h004, 1, 1, 32'h00212342, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h008, 1, 1, 32'h00312343, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h010, 1, 1, 32'h00412344, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h020, 1, 1, 32'h00512345, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h040, 1, 1, 32'h00612346, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h080, 1, 1, 32'h00712347, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h100, 1, 1, 32'h00812348, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h1FF, 20'h12340, 1, 9'h000, 9'h001, 1, 1, 32'h00012340, 9'h0, 9'h0));
    tbl.push_back(mk(1, 9'h000, 20'h12340, 1, 9'h000, 9'h000, 0, 1, 32'h00012340, 9'h0, 9'h0));

    @(posedge clk);
    #1;
    foreach (tbl[k]) apply(tbl[k]);

    // backpressure: output held 5 cycles, drain and reload in the same cycle
    apply(mk(0, 9'h000, 20'h00000, 1, 9'h000, 9'h000, 0, 1, 32'h0, 9'h0, 9'h0));
    apply(mk(1, 9'h002, 20'h55550, 1, 9'h000, 9'h002, 1, 1, 32'h00155551, 9'h0, 9'h0));
    for (int c = 0; c < 5; c++)
      apply(mk(1, 9'h002, 20'h99990, 0, 9'h000, 9'h000, 1, 1, 32'h00155551, 9'h0, 9'h0));
    apply(mk(1, 9'h002, 20'h99990, 1, 9'h000, 9'h002, 1, 1, 32'h00199991, 9'h0, 9'h0));
    apply(mk(1, 9'h000, 20'h99990, 1, 9'h000, 9'h000, 0, 1, 32'h00199991, 9'h0, 9'h0));

    // outstanding limit on port 0
    apply(mk(0, 9'h000, 20'h00000, 1, 9'h000, 9'h000, 0, 1, 32'h0, 9'h0, 9'h0));
    for (int c = 0; c < 4; c++)
      apply(mk(1, 9'h001, 20'h3C3C0, 1, 9'h000, 9'h001, 1, 1, 32'h0003C3C0, 9'h0, 9'h0));
    apply(mk(1, 9'h001, 20'h3C3C0, 1, 9'h000, 9'h000, 0, 1, 32'h0003C3C0, 9'h001, 9'h0));
    apply(mk(1, 9'h001, 20'h3C3C0, 1, 9'h001, 9'h000, 0, 1, 32'h0003C3C0, 9'h001, 9'h0));
    apply(mk(1, 9'h001, 20'h3C3C0, 1, 9'h000, 9'h001, 1, 1, 32'h0003C3C0, 9'h000, 9'h0));
    apply(mk(1, 9'h001, 20'h3C3C0, 1, 9'h000, 9'h000, 0, 1, 32'h0003C3C0, 9'h001, 9'h0));

    // grant and return together on port 3 at cnt 2, then underflow on port 5
    apply(mk(0, 9'h000, 20'h00000, 1, 9'h000, 9'h000, 0, 1, 32'h0, 9'h0, 9'h0));
    for (int c = 0; c < 2; c++)
      apply(mk(1, 9'h008, 20'h00A00, 1, 9'h000, 9'h008, 1, 1, 32'h00300A03, 9'h0, 9'h0));
    apply(mk(1, 9'h008, 20'h00A00, 1, 9'h008, 9'h008, 1, 1, 32'h00300A03, 9'h0, 9'h0));
    for (int c = 0; c < 2; c++)
      apply(mk(1, 9'h008, 20'h00A00, 1, 9'h000, 9'h008, 1, 1, 32'h00300A03, 9'h0, 9'h0));
    apply(mk(1, 9'h008, 20'h00A00, 1, 9'h000, 9'h000, 0, 1, 32'h00300A03, 9'h008, 9'h0));
    apply(mk(1, 9'h000, 20'h00A00, 1, 9'h020, 9'h000, 0, 1, 32'h00300A03, 9'h008, 9'h020));
    apply(mk(1, 9'h000, 20'h00A00, 1, 9'h000, 9'h000, 0, 1, 32'h00300A03, 9'h008, 9'h020));
    apply(mk(1, 9'h020, 20'h00A00, 1, 9'h000, 9'h020, 1, 1, 32'h00500A05, 9'h008, 9'h020));

    // reset mid-operation with a held request and port 0 at its limit
    apply(mk(0, 9'h000, 20'h00000, 1, 9'h000, 9'h000, 0, 1, 32'h0, 9'h0, 9'h0));
    for (int c = 0; c < 4; c++)
      apply(mk(1, 9'h001, 20'h77770, 1, 9'h000, 9'h001, 1, 1, 32'h00077770, 9'h0, 9'h0));
    apply(mk(1, 9'h1FF, 20'h77770, 0, 9'h000, 9'h000, 1, 1, 32'h00077770, 9'h001, 9'h0));
    apply(mk(0, 9'h1FF, 20'h77770, 0, 9'h000, 9'h000, 0, 1, 32'h0, 9'h000, 9'h0));
    apply(mk(1, 9'h1FF, 20'h77770, 1, 9'h000, 9'h001, 1, 1, 32'h00077770, 9'h000, 9'h0));
    apply(mk(1, 9'h1FF, 20'h77770, 1, 9'h000, 9'h002, 1, 1, 32'h00177771, 9'h000, 9'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
